// File: rtl/serial_in_scanner_pkg.sv
// Shared state encoding and width helper for the 74LV165 chain scanner.
package serial_in_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_EVAL  = 2'd3
  } scan_state_t;

  // Bits needed to hold 0..value-1, never less than one so counters stay declarable.
  function automatic int clog2_min1(input int value);
    int width;
    width = 32'sd1;
    for (int i = 32'sd1; i < 32'sd31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 32'sd1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/serial_in_scanner_tick.sv
// Shift-clock prescaler: splits each bit slot into a DIV-cycle low half and a DIV-cycle high half.
module sr_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sample,
  output logic slot_end
);
  import serial_in_scanner_pkg::*;

  localparam int CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_r;
  logic          phase_r;

  // Counts inside a half-period; phase_r marks the high half of the slot.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt_r <= '0;
      phase_r   <= 1'b0;
    end else if (div_cnt_r == LAST) begin
      div_cnt_r <= '0;
      phase_r   <= ~phase_r;
    end else begin
      div_cnt_r <= div_cnt_r + 1'b1;
    end
  end

  assign sample   = run && !phase_r && (div_cnt_r == LAST);
  assign slot_end = run &&  phase_r && (div_cnt_r == LAST);

endmodule

// File: rtl/serial_in_scanner.sv
// Scans CHANNELS parallel 74LV165 chains, debounces whole frames and reports per-bit edges.
module serial_in_scanner #(
  parameter int CHANNELS     = 3,
  parameter int BITS         = 24,
  parameter int DIV          = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_en,
  output logic                     sclk,
  output logic                     shldn,
  input  logic [CHANNELS-1:0]      qh,
  output logic [CHANNELS*BITS-1:0] data,
  output logic                     data_valid,
  output logic                     frame_strobe,
  output logic [CHANNELS*BITS-1:0] rise_pulse,
  output logic [CHANNELS*BITS-1:0] fall_pulse
);
  import serial_in_scanner_pkg::*;

  localparam int W    = CHANNELS * BITS;
  localparam int SW   = clog2_min1(BITS);
  localparam int CNTW = clog2_min1(STABLE_SCANS + 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(BITS - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(STABLE_SCANS);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  scan_state_t                        state_r;
  logic [SW-1:0]                      slot_r;
  logic [CHANNELS-1:0][BITS-1:0]      raw_r;
  logic [CHANNELS-1:0][BITS-1:0]      prev_r;
  logic [CNTW-1:0]                    cnt_r;
  logic                               sclk_r;
  logic                               shldn_r;
  logic [W-1:0]                       data_r;
  logic                               data_valid_r;
  logic                               frame_strobe_r;
  logic [W-1:0]                       rise_r;
  logic [W-1:0]                       fall_r;

  logic                               tick_run_s;
  logic                               sample_s;
  logic                               slot_end_s;
  logic [W-1:0]                       raw_flat_s;
  logic [CNTW-1:0]                    cnt_next_s;
  logic                               accept_s;

  assign tick_run_s = (state_r == ST_LOAD) || (state_r == ST_SHIFT);
  assign raw_flat_s = raw_r;

  sr_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .run      (tick_run_s),
    .sample   (sample_s),
    .slot_end (slot_end_s)
  );

  // Stability count for the frame just shifted in and the resulting accept decision.
  always_comb begin
    cnt_next_s = CNT_ONE;
    accept_s   = 1'b0;
    if (raw_r == prev_r) begin
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = CNT_MAX;
      end else begin
        cnt_next_s = cnt_r + 1'b1;
      end
    end else begin
      cnt_next_s = CNT_ONE;
    end
    if ((cnt_next_s == CNT_MAX) && ((raw_flat_s != data_r) || !data_valid_r)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Scan sequencer, bit capture and accepted-frame update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      slot_r         <= '0;
      raw_r          <= '0;
      prev_r         <= '0;
      cnt_r          <= '0;
      sclk_r         <= 1'b0;
      shldn_r        <= 1'b1;
      data_r         <= '0;
      data_valid_r   <= 1'b0;
      frame_strobe_r <= 1'b0;
      rise_r         <= '0;
      fall_r         <= '0;
    end else begin
      frame_strobe_r <= 1'b0;
      rise_r         <= '0;
      fall_r         <= '0;
      case (state_r)
        ST_IDLE: begin
          sclk_r <= 1'b0;
          if (scan_en) begin
            state_r <= ST_LOAD;
            shldn_r <= 1'b0;
          end else begin
            shldn_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          sclk_r <= 1'b0;
          if (slot_end_s) begin
            state_r <= ST_SHIFT;
            shldn_r <= 1'b1;
            slot_r  <= '0;
          end
        end
        ST_SHIFT: begin
          // First bit out of each chain is its MSB, so slot k lands at BITS-1-k.
          if (sample_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
              raw_r[c][SLOT_LAST - slot_r] <= qh[c];
            end
            sclk_r <= 1'b1;
          end
          if (slot_end_s) begin
            sclk_r <= 1'b0;
            if (slot_r == SLOT_LAST) begin
              state_r <= ST_EVAL;
            end else begin
              slot_r <= slot_r + 1'b1;
            end
          end
        end
        ST_EVAL: begin
          sclk_r <= 1'b0;
          cnt_r  <= cnt_next_s;
          prev_r <= raw_r;
          if (accept_s) begin
            data_r         <= raw_flat_s;
            data_valid_r   <= 1'b1;
            frame_strobe_r <= 1'b1;
            if (data_valid_r) begin
              rise_r <= raw_flat_s & ~data_r;
              fall_r <= ~raw_flat_s & data_r;
            end
          end
          if (scan_en) begin
            state_r <= ST_LOAD;
            shldn_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            shldn_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          shldn_r <= 1'b1;
        end
      endcase
    end
  end

  assign sclk         = sclk_r;
  assign shldn        = shldn_r;
  assign data         = data_r;
  assign data_valid   = data_valid_r;
  assign frame_strobe = frame_strobe_r;
  assign rise_pulse   = rise_r;
  assign fall_pulse   = fall_r;

endmodule

// File: tb/tb_serial_in_scanner.sv
// Scoreboard bench: behavioural 74LV165 chains feed two scanner instances; monitors check each update.
module tb_serial_in_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, scan_en1, sclk1, shldn1, valid1, strobe1;
  logic [2:0]  qh1;
  logic [71:0] data1, rise1, fall1;
  logic        rst2, scan_en2, sclk2, shldn2, valid2, strobe2;
  logic [0:0]  qh2;
  logic [7:0]  data2, rise2, fall2;

  serial_in_scanner #(.CHANNELS(3), .BITS(24), .DIV(4), .STABLE_SCANS(2)) dut1 (
    .clk(clk), .reset(rst1), .scan_en(scan_en1), .sclk(sclk1), .shldn(shldn1), .qh(qh1),
    .data(data1), .data_valid(valid1), .frame_strobe(strobe1),
    .rise_pulse(rise1), .fall_pulse(fall1));

  serial_in_scanner #(.CHANNELS(1), .BITS(8), .DIV(1), .STABLE_SCANS(1)) dut2 (
    .clk(clk), .reset(rst2), .scan_en(scan_en2), .sclk(sclk2), .shldn(shldn2), .qh(qh2),
    .data(data2), .data_valid(valid2), .frame_strobe(strobe2),
    .rise_pulse(rise2), .fall_pulse(fall2));

  // 74LV165 chain models: parallel load while SH/LDn low, shift on each sclk rise.
  logic [23:0] par1 [3];
  logic [23:0] sh1  [3];
  logic        sclk1_d;
  logic [7:0]  par2, sh2;
  logic        sclk2_d;

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (!shldn1) sh1[c] <= par1[c];
      else if (sclk1 && !sclk1_d) sh1[c] <= sh1[c] << 1;
    end
    sclk1_d <= sclk1;
    if (!shldn2) sh2 <= par2;
    else if (sclk2 && !sclk2_d) sh2 <= sh2 << 1;
    sclk2_d <= sclk2;
  end

  assign qh1 = {sh1[2][23], sh1[1][23], sh1[0][23]};
  assign qh2 = sh2[7];

  typedef struct {
    logic [71:0] d;
    logic [71:0] r;
    logic [71:0] f;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   strobes1 = 0;
  int   strobes2 = 0;
  logic prev_s1  = 1'b0;
  logic prev_s2  = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [71:0] d, input logic [71:0] r, input logic [71:0] f);
    exp_t e;
    e.d = d;
    e.r = r;
    e.f = f;
    if (sel) q2.push_back(e);
    else q1.push_back(e);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (prev_s1) check("dut1 pulse width", {69'd0, strobe1, |rise1, |fall1}, 72'd0);
    if (strobe1 === 1'b1) begin
      strobes1++;
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1 unexpected strobe: got data %0h, expected no update", data1);
      end else begin
        e = q1.pop_front();
        check("dut1 data", data1, e.d);
        check("dut1 rise", rise1, e.r);
        check("dut1 fall", fall1, e.f);
        check("dut1 valid on strobe", 72'(valid1), 72'd1);
      end
    end
    prev_s1 = strobe1;
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (prev_s2) check("dut2 pulse width", {69'd0, strobe2, |rise2, |fall2}, 72'd0);
    if (strobe2 === 1'b1) begin
      strobes2++;
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut2 unexpected strobe: got data %0h, expected no update", data2);
      end else begin
        e = q2.pop_front();
        check("dut2 data", 72'(data2), e.d);
        check("dut2 rise", 72'(rise2), e.r);
        check("dut2 fall", 72'(fall2), e.f);
        check("dut2 valid on strobe", 72'(valid2), 72'd1);
      end
    end
    prev_s2 = strobe2;
  end

  task automatic wait_load(input bit sel);
    int n = 0;
    bit seen_low = 1'b0;
    bit done = 1'b0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
      if ((sel ? shldn2 : shldn1) == 1'b0) seen_low = 1'b1;
      else if (seen_low) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_load timeout: got no completed load, expected one within 1000 cycles");
    end
  endtask

  task automatic wait_q(input bit sel, input int limit);
    int n = 0;
    while (((sel ? q2.size() : q1.size()) != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "dut2 expected update seen" : "dut1 expected update seen",
          72'(sel ? q2.size() : q1.size()), 72'd0);
  endtask

  task automatic measure_period(input bit sel, input int exp_p, input string name);
    int   t0 = -1;
    int   n = 0;
    int   p = 0;
    logic prev = 1'b1;
    logic cur;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      cur = sel ? shldn2 : shldn1;
      if (prev && !cur) begin
        if (t0 < 0) t0 = n;
        else begin
          p = n - t0;
          break;
        end
      end
      prev = cur;
    end
    check(name, 72'(p), 72'(exp_p));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected end within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int n;
    int rises;
    int lows;
    int bad;
    logic sclk_prev;

    rst1 = 1'b1; rst2 = 1'b1; scan_en1 = 1'b0; scan_en2 = 1'b1;
    par1[0] = 24'hA5A5A5; par1[1] = 24'h0; par1[2] = 24'h0; par2 = 8'h0F;
    repeat (4) @(negedge clk);
    check("dut1 reset ctl", {68'd0, sclk1, shldn1, valid1, strobe1}, 72'b0100);
    check("dut1 reset data", data1, 72'd0);
    check("dut1 reset pulses", rise1 | fall1, 72'd0);
    check("dut2 reset ctl", {68'd0, sclk2, shldn2, valid2, strobe2}, 72'b0100);

    // Steady frame: accepted after two identical scans, no edges on first accept.
    push(1'b0, {24'h0, 24'h0, 24'hA5A5A5}, 72'd0, 72'd0);
    rst1 = 1'b0; scan_en1 = 1'b1;
    measure_period(1'b0, 201, "dut1 frame period");
    wait_q(1'b0, 500);
    check("dut1 data_valid", 72'(valid1), 72'd1);
    check("dut1 strobe count", 72'(strobes1), 72'd1);

    // One-frame glitch on chain1 bit0 is rejected.
    s = strobes1;
    wait_load(1'b0); par1[1] = 24'h000001;
    wait_load(1'b0); par1[1] = 24'h000000;
    repeat (3 * 201) @(negedge clk);
    check("dut1 bounce strobes", 72'(strobes1 - s), 72'd0);
    check("dut1 data after bounce", data1, {24'h0, 24'h0, 24'hA5A5A5});

    // Held change on chain1 bit0 is accepted with a single rise pulse.
    wait_load(1'b0); par1[1] = 24'h000001;
    push(1'b0, {24'h0, 24'h1, 24'hA5A5A5}, 72'd1 << 24, 72'd0);
    wait_q(1'b0, 3 * 201 + 50);
    repeat (10) @(negedge clk);
    check("dut1 data holds", data1, {24'h0, 24'h1, 24'hA5A5A5});

    // scan_en dropped mid-SHIFT: frame runs to completion, then idles.
    wait_load(1'b0);
    rises = 0; lows = 0; bad = 0; sclk_prev = sclk1;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (i == 20) scan_en1 = 1'b0;
      if (sclk1 && !sclk_prev) rises++;
      sclk_prev = sclk1;
      if (!shldn1) lows++;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sclk1 !== 1'b0 || shldn1 !== 1'b1) bad++;
    end
    check("dut1 stop sclk rises", 72'(rises), 72'd24);
    check("dut1 stop no reload", 72'(lows), 72'd0);
    check("dut1 idle held", 72'(bad), 72'd0);

    // Reset in the middle of a frame aborts it and forces a two-frame rescan.
    scan_en1 = 1'b1;
    wait_load(1'b0);
    repeat (30) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    check("dut1 midframe reset ctl", {68'd0, sclk1, shldn1, valid1, strobe1}, 72'b0100);
    check("dut1 midframe reset data", data1, 72'd0);
    rst1 = 1'b0;
    push(1'b0, {24'h0, 24'h1, 24'hA5A5A5}, 72'd0, 72'd0);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (valid1 === 1'b1) break;
    end
    check("dut1 rescan latency", 72'(n), 72'd403);
    wait_q(1'b0, 50);

    // DIV=1, BITS=8, STABLE_SCANS=1: every changed frame is accepted.
    push(1'b1, 72'h0F, 72'd0, 72'd0);
    rst2 = 1'b0;
    measure_period(1'b1, 19, "dut2 frame period");
    wait_q(1'b1, 40);
    wait_load(1'b1); par2 = 8'hF0;
    push(1'b1, 72'hF0, 72'hF0, 72'h0F);
    wait_q(1'b1, 60);
    s = strobes2;
    repeat (4 * 19) @(negedge clk);
    check("dut2 unchanged no strobe", 72'(strobes2 - s), 72'd0);
    wait_load(1'b1); par2 = 8'hF5;
    push(1'b1, 72'hF5, 72'h05, 72'h00);
    wait_q(1'b1, 60);
    check("dut2 strobe count", 72'(strobes2), 72'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
